// File: rtl/ccl_labeler_param.sv
// First-pass connected-components labeler: picks a label from the causal
// neighbourhood (A B C / D p), allocates new labels, records merges in two
// ping-pong stacks that drain into a merge table, and resolves the output
// label through that table.
module ccl_labeler_param #(
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned DEPTH   = 16,   // power of 2, at least 2
  parameter bit          CONN8   = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               frame_start,
  input  logic               line_end,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  input  logic [LABEL_W-1:0] pix,
  output logic [LABEL_W-1:0] q,
  output logic               q_valid,
  output logic [LABEL_W-1:0] num_labels,
  output logic               label_overflow,
  output logic               merge_overflow
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = 2 * LABEL_W;
  localparam int unsigned NLAB    = 1 << LABEL_W;
  localparam logic [LABEL_W-1:0] MAX_LABEL = {LABEL_W{1'b1}};
  localparam logic [PTR_W-1:0]   FULL_PTR  = PTR_W'(DEPTH);

  logic [LABEL_W-1:0] tbl [NLAB];
  logic [NLAB-1:0]    written;        // table entries written in this frame
  logic [ENTRY_W-1:0] stk [2][DEPTH];
  logic [PTR_W-1:0]   ptr [2];
  logic               bank;           // bank currently receiving pushes
  logic [ENTRY_W-1:0] hist;           // last entry pushed in this row
  logic               hist_vld;

  logic [LABEL_W-1:0] nb [4];
  logic [LABEL_W-1:0] nz_min, nz_max;
  logic               any_nz;
  logic               is_fg, is_new, is_merge, alloc_ok, alloc_wr;
  logic [LABEL_W-1:0] nl_eff, label;
  logic               bank_eff, hist_vld_eff, dup;
  logic               push_req, push_full, do_push, do_pop;
  logic [PTR_W-1:0]   push_ptr, pop_ptr, push_ptr_nxt, pop_ptr_nxt;
  logic [ENTRY_W-1:0] entry, top;
  logic               we;
  logic [LABEL_W-1:0] waddr, wdata, q_next;

  // Min / max over the nonzero (unmasked) neighbours
  always_comb begin
    nb[0]  = CONN8 ? A : '0;
    nb[1]  = B;
    nb[2]  = CONN8 ? C : '0;
    nb[3]  = D;
    nz_min = MAX_LABEL;
    nz_max = '0;
    any_nz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (nb[i] != '0) begin
        any_nz = 1'b1;
        if (nb[i] < nz_min) nz_min = nb[i];
        if (nb[i] > nz_max) nz_max = nb[i];
      end
    end
  end

  // Label choice, push/pop decisions, table write port and output resolve
  always_comb begin
    // frame_start makes this pixel the first of a fresh frame
    nl_eff       = frame_start ? LABEL_W'(1) : num_labels;
    bank_eff     = frame_start ? 1'b0 : bank;
    hist_vld_eff = hist_vld && !frame_start;
    push_ptr     = frame_start ? '0 : (bank_eff ? ptr[1] : ptr[0]);
    pop_ptr      = frame_start ? '0 : (bank_eff ? ptr[0] : ptr[1]);

    is_fg    = pix != '0;
    alloc_ok = nl_eff != MAX_LABEL;
    is_new   = is_fg && !any_nz;
    is_merge = is_fg && any_nz && (nz_min != nz_max);
    alloc_wr = en && is_new && alloc_ok;

    label = '0;
    if (is_new)     label = alloc_ok ? nl_eff : '0;
    else if (is_fg) label = nz_min;

    entry     = {nz_max, nz_min};
    dup       = hist_vld_eff && (hist == entry);
    push_req  = en && is_merge && !dup;
    push_full = push_ptr == FULL_PTR;
    do_push   = push_req && !push_full;

    // Allocation owns the single table write port; pop waits a cycle
    do_pop = en && (pop_ptr != '0) && !alloc_wr;
    top    = stk[~bank_eff][ADDR_W'(pop_ptr - PTR_W'(1))];

    push_ptr_nxt = push_ptr + PTR_W'(do_push);
    pop_ptr_nxt  = pop_ptr - PTR_W'(do_pop);

    we    = alloc_wr || do_pop;
    waddr = alloc_wr ? nl_eff : top[ENTRY_W-1:LABEL_W];
    wdata = alloc_wr ? nl_eff : top[LABEL_W-1:0];

    // Write-first forwarding, then table, then identity for unwritten labels
    if (label == '0)                            q_next = '0;
    else if (we && (waddr == label))           q_next = wdata;
    else if (written[label] && !frame_start)   q_next = tbl[label];
    else                                       q_next = label;
  end

  // Frame/row state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q              <= '0;
      q_valid        <= 1'b0;
      num_labels     <= LABEL_W'(1);
      label_overflow <= 1'b0;
      merge_overflow <= 1'b0;
      bank           <= 1'b0;
      ptr[0]         <= '0;
      ptr[1]         <= '0;
      hist           <= '0;
      hist_vld       <= 1'b0;
      written        <= '0;
    end else if (en) begin
      q              <= q_next;
      q_valid        <= 1'b1;
      num_labels     <= alloc_wr ? nl_eff + LABEL_W'(1) : nl_eff;
      label_overflow <= (label_overflow && !frame_start) || (is_new && !alloc_ok);
      merge_overflow <= (merge_overflow && !frame_start) || (push_req && push_full);
      ptr[0]         <= bank_eff ? pop_ptr_nxt : push_ptr_nxt;
      ptr[1]         <= bank_eff ? push_ptr_nxt : pop_ptr_nxt;
      bank           <= bank_eff ^ line_end;
      if (do_push) hist <= entry;
      hist_vld       <= !line_end && (do_push || hist_vld_eff);
      if (frame_start) written <= '0;
      if (we) written[waddr] <= 1'b1;
    end
  end

  // Merge table and stack storage
  always_ff @(posedge clk) begin
    if (we) tbl[waddr] <= wdata;
    if (do_push) stk[bank_eff][ADDR_W'(push_ptr)] <= entry;
  end

endmodule
